regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 35 +++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    // Clear sequencer owns the array in CLEAR; external ports own it in READY.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: forces zero, forwards same-cycle writes, or returns the array word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a read is always served in the cycle it is presented.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     rst,
    input  logic                     busy,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [NUM_WR-1:0]        wr_vld,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]        arr_dat,
    output logic [DATA_W-1:0]        rdata
);

    // Array word, overridden by the highest-indexed matching write, overridden by the zero cases.
    always_comb begin
        rdata = arr_dat;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_vld[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
                rdata = wdata[i*DATA_W +: DATA_W];
            end
        end
        if (rst || busy || !re || (raddr == '0)) begin
            rdata = DATA_W'(ZERO_WORD);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear after reset and write-to-read bypass.
// Latency: writes land at the next rising edge; reads are combinational with bypass.
// Backpressure: none; while init_busy is high writes are dropped and reads return zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic [NUM_WR-1:0]   wr_vld;
    logic [DATA_W-1:0]   regs   [DEPTH];
    logic [DATA_W-1:0]   arr_rd [NUM_RD];

    // Clear sequencer: walks addresses 1..DEPTH-1 once, then hands the array over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= ADDR_W'(1);
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        clr_addr  <= clr_addr + ADDR_W'(1);
                    end
                end
                READY: begin
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    clr_addr  <= ADDR_W'(1);
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // A write port is live only in READY, outside reset, and never to address 0.
    always_comb begin
        wr_vld = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_vld[i] = we[i] && !rst && !init_busy && (waddr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Array update: sequencer zeroes in CLEAR, otherwise ascending port loop so the highest index wins.
    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            regs[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_vld[i]) begin
                    regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    genvar j;
    generate
        for (j = 0; j < NUM_RD; j++) begin : g_rd
            assign arr_rd[j] = regs[raddr[j*ADDR_W +: ADDR_W]];

            regfile_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NUM_WR (NUM_WR)
            ) u_rd_port (
                .rst     (rst),
                .busy    (init_busy),
                .re      (re[j]),
                .raddr   (raddr[j*ADDR_W +: ADDR_W]),
                .wr_vld  (wr_vld),
                .waddr   (waddr),
                .wdata   (wdata),
                .arr_dat (arr_rd[j]),
                .rdata   (rdata[j*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (32 x 32-bit, 2R/2W).
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic [1:0]  re;
        logic [9:0]  raddr;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after rst falls; counts busy cycles and watches rdata.
    task automatic wait_clear(input string tag);
        int  n;
        bit  zero_ok;
        n = 0;
        zero_ok = 1'b1;
        for (int k = 0; k < 100 && init_busy === 1'b1; k++) begin
            if (rdata !== 64'd0) zero_ok = 1'b0;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd31);
        chk({tag, "_rdata_zero_while_busy"}, 64'(zero_ok), 64'd1);
        chk({tag, "_busy_low_after"}, 64'(init_busy), 64'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] w_en, input logic [4:0] wa1, input logic [4:0] wa0,
                                input logic [31:0] wd1, input logic [31:0] wd0,
                                input logic [1:0] r_en, input logic [4:0] ra1, input logic [4:0] ra0,
                                input logic [31:0] e1, input logic [31:0] e0);
        vec_t v;
        v.we    = w_en;
        v.waddr = {wa1, wa0};
        v.wdata = {wd1, wd0};
        v.re    = r_en;
        v.raddr = {ra1, ra0};
        v.exp   = {e1, e0};
        return v;
    endfunction

    initial begin
        // Port0 writes r7, port1 reads r7 through bypass, then from the array.
        vt[0]  = mk(2'b01, 5'd0, 5'd7, 32'h0, 32'h1234_5678, 2'b10, 5'd7, 5'd0, 32'h1234_5678, 32'h0);
        vt[1]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);
        // Both ports write r3: port1 wins in bypass and in the array.
        vt[2]  = mk(2'b11, 5'd3, 5'd3, 32'h5555_5555, 32'hAAAA_AAAA, 2'b11, 5'd3, 5'd3, 32'h5555_5555, 32'h5555_5555);
        vt[3]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd7, 5'd3, 32'h1234_5678, 32'h5555_5555);
        // Writes to r0 are dropped and r0 reads zero.
        vt[4]  = mk(2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0);
        vt[5]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0);
        // Port1 writes r9; disabled port1 read is zero, port0 sees the bypass.
        vt[6]  = mk(2'b10, 5'd9, 5'd0, 32'h0000_0042, 32'h0, 2'b01, 5'd9, 5'd9, 32'h0, 32'h0000_0042);
        vt[7]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b10, 5'd9, 5'd9, 32'h0000_0042, 32'h0);
        // Two different addresses written, read crosswise.
        vt[8]  = mk(2'b11, 5'd10, 5'd9, 32'h0000_BEEF, 32'h0000_0099, 2'b11, 5'd9, 5'd10, 32'h0000_0099, 32'h0000_BEEF);
        vt[9]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd9, 5'd10, 32'h0000_0099, 32'h0000_BEEF);
        // we=0 must neither bypass nor write.
        vt[10] = mk(2'b00, 5'd12, 5'd12, 32'hCAFE_0001, 32'hCAFE_0000, 2'b11, 5'd12, 5'd12, 32'h0, 32'h0);
        vt[11] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd12, 5'd12, 32'h0, 32'h0);

        // Reset with writes to r5 pending on both ports.
        rst   = 1'b1;
        we    = 2'b11;
        waddr = {5'd5, 5'd5};
        wdata = {32'hDEAD_0001, 32'hDEAD_0000};
        re    = 2'b11;
        raddr = {5'd5, 5'd5};
        tick();
        tick();
        chk("reset_busy", 64'(init_busy), 64'd1);
        chk("reset_rdata", rdata, 64'd0);

        rst = 1'b0;
        wait_clear("init");
        we = 2'b00;
        #1;
        chk("init_r5_still_zero", rdata, 64'd0);
        tick();

        for (int v = 0; v < 12; v++) begin
            we    = vt[v].we;
            waddr = vt[v].waddr;
            wdata = vt[v].wdata;
            re    = vt[v].re;
            raddr = vt[v].raddr;
            #1;
            chk($sformatf("vec%0d_rdata", v), rdata, vt[v].exp);
            chk($sformatf("vec%0d_busy", v), 64'(init_busy), 64'd0);
            tick();
        end

        // Fill r1..r31 with their own index through port0.
        re = 2'b00;
        for (int i = 1; i < 32; i++) begin
            we    = 2'b01;
            waddr = {5'd0, 5'(i)};
            wdata = {32'd0, 32'(i)};
            tick();
        end
        we    = 2'b00;
        re    = 2'b11;
        raddr = {5'd31, 5'd17};
        #1;
        chk("fill_r31_r17", rdata, {32'd31, 32'd17});
        tick();

        // Reset in READY with a same-cycle write; rdata must read zero.
        rst   = 1'b1;
        we    = 2'b01;
        waddr = {5'd0, 5'd20};
        wdata = {32'd0, 32'hDEAD_BEEF};
        raddr = {5'd20, 5'd20};
        #1;
        chk("rst_ready_rdata", rdata, 64'd0);
        tick();
        we  = 2'b00;
        rst = 1'b0;
        repeat (9) tick();
        chk("midclr_busy_before_rst", 64'(init_busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("midclr_busy_in_rst", 64'(init_busy), 64'd1);
        rst = 1'b0;
        wait_clear("midclr");

        for (int i = 1; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            #1;
            chk($sformatf("cleared_r%0d", i), rdata, 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
